// File: rtl/sram_pager.sv
// CPU front end for the SRAM stage: decodes sram_cs, holds the page register, and stretches SRAM cycles.
// Decode is combinational; ready drops for WAIT_STATES cycles per SRAM access; I/O and page accesses never stall.
module sram_pager #(
  parameter logic [15:0] PAGE_REG_ADDR = 16'hE6D0,
  parameter logic [15:0] IO_LO         = 16'hE600,
  parameter logic [15:0] IO_HI         = 16'hE6FF,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] AD,
  input  logic [7:0]  DI,
  input  logic        rw,
  input  logic        vma,
  output logic [7:0]  DO,
  output logic        page_sel,
  output logic [4:0]  page,
  output logic        sram_cs,
  output logic        ready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LAST} state_t;

  // WAIT covers the stall cycles between the first one (spent in IDLE) and LAST.
  localparam logic [2:0] CNT_INIT = (WAIT_STATES >= 2) ? 3'(WAIT_STATES - 2) : 3'd0;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       mem_sel, page_hit, page_wr, stall_en, rdy;
  logic       unused_di;

  assign stall_en  = (WAIT_STATES != 0);
  assign mem_sel   = vma && !((AD >= IO_LO) && (AD <= IO_HI));
  assign page_hit  = (AD == PAGE_REG_ADDR);
  assign page_sel  = vma && rw && page_hit;
  assign page_wr   = vma && !rw && page_hit;
  assign DO        = {3'b000, page};
  assign sram_cs   = mem_sel && !rst;
  assign ready     = rst || rdy;
  assign unused_di = ^DI[7:5];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdy       = 1'b1;
    case (state)
      S_IDLE: begin
        rdy = !(stall_en && mem_sel);
        if (stall_en && mem_sel) begin
          if (WAIT_STATES == 1) begin
            state_nxt = S_LAST;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Losing vma means the CPU abandoned the access; release it at once.
        if (!vma) begin
          state_nxt = S_IDLE;
        end else begin
          rdy = 1'b0;
          if (cnt != 3'd0) begin
            cnt_nxt = cnt - 3'd1;
          end else begin
            state_nxt = S_LAST;
          end
        end
      end
      S_LAST: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      page  <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (page_wr) begin
        page <= DI[4:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_pager.sv
// Bench for sram_pager: three instances (WAIT_STATES 1, 3, 0) share one stimulus stream.
module tb_sram_pager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] AD  = 16'h0000;
  logic [7:0]  DI  = 8'h00;
  logic        rw  = 1'b1;
  logic        vma = 1'b0;

  logic [7:0] do1, do3, do0;
  logic [4:0] pg1, pg3, pg0;
  logic       ps1, ps3, ps0, cs1, cs3, cs0, rd1, rd3, rd0;

  sram_pager #(.WAIT_STATES(1)) u_w1 (.clk(clk), .rst(rst), .AD(AD), .DI(DI), .rw(rw), .vma(vma),
    .DO(do1), .page_sel(ps1), .page(pg1), .sram_cs(cs1), .ready(rd1));
  sram_pager #(.WAIT_STATES(3)) u_w3 (.clk(clk), .rst(rst), .AD(AD), .DI(DI), .rw(rw), .vma(vma),
    .DO(do3), .page_sel(ps3), .page(pg3), .sram_cs(cs3), .ready(rd3));
  sram_pager #(.WAIT_STATES(0)) u_w0 (.clk(clk), .rst(rst), .AD(AD), .DI(DI), .rw(rw), .vma(vma),
    .DO(do0), .page_sel(ps0), .page(pg0), .sram_cs(cs0), .ready(rd0));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per instance, the age of the access in progress (-1 = none).
  // An access stalls while its age is below W and completes at age W.
  int         wv[3] = '{1, 3, 0};
  int         age[3] = '{-1, -1, -1};
  logic [4:0] m_page = 5'd0;

  function automatic logic in_sram();
    return vma && !(AD >= 16'hE600 && AD <= 16'hE6FF);
  endfunction

  function automatic logic exp_ready(int i);
    if (rst) return 1'b1;
    if (age[i] < 0) return !(in_sram() && wv[i] > 0);
    if (!vma) return 1'b1;
    return (age[i] == wv[i]);
  endfunction

  task automatic model_check();
    logic ecs, eps;
    ecs = in_sram() && !rst;
    eps = vma && rw && (AD == 16'hE6D0);
    chk("ready_w1", rd1, exp_ready(0));
    chk("ready_w3", rd3, exp_ready(1));
    chk("ready_w0", rd0, exp_ready(2));
    chk("sram_cs_w1", cs1, ecs);
    chk("sram_cs_w0", cs0, ecs);
    chk("page_sel_w3", ps3, eps);
    chk("DO_w1", do1, {3'b000, m_page});
    chk("page_w3", pg3, m_page);
    chk("page_w0", pg0, m_page);
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) age[i] = -1;
      else if (age[i] < 0) age[i] = (in_sram() && wv[i] > 0) ? 1 : -1;
      else if (!vma || age[i] == wv[i]) age[i] = -1;
      else age[i] = age[i] + 1;
    end
    if (rst) m_page = 5'd0;
    else if (vma && !rw && AD == 16'hE6D0) m_page = DI[4:0];
  endtask

  // Drive a cycle's inputs and move to the falling edge where outputs are sampled.
  task automatic apply(input logic r, input logic [15:0] a, input logic [7:0] d,
                       input logic w, input logic v);
    rst = r; AD = a; DI = d; rw = w; vma = v;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] ad;
    logic [7:0]  di;
    logic        rw;
    logic        vma;
    logic        r1;
    logic        r3;
    logic        cs;
    logic        ps;
    logic [7:0]  dout;
  } vec_t;

  function automatic vec_t mk(logic r, logic [15:0] a, logic [7:0] d, logic w, logic v,
                              logic r1, logic r3, logic cs, logic ps, logic [7:0] dout);
    vec_t t;
    t.rst = r; t.ad = a; t.di = d; t.rw = w; t.vma = v;
    t.r1 = r1; t.r3 = r3; t.cs = cs; t.ps = ps; t.dout = dout;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [15:0] a;
    int step;

    // reset, then a W=1 / W=3 read, a back-to-back write, page register traffic, abort and reset mid-stall
    tbl.push_back(mk(1, 16'h0100, 8'h00, 1, 1,  1, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 16'h0100, 8'h00, 1, 1,  1, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 16'h0100, 8'h00, 1, 1,  0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'h0100, 8'h00, 1, 1,  1, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'h0100, 8'h00, 1, 1,  0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'h0100, 8'h00, 1, 1,  1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'hC000, 8'h55, 0, 1,  0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'hC000, 8'h55, 0, 1,  1, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'hC000, 8'h55, 0, 1,  0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'hC000, 8'h55, 0, 1,  1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 0,  1, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 16'hE6D0, 8'hFB, 0, 1,  1, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 16'hE6D0, 8'h00, 1, 1,  1, 1, 0, 1, 8'h1B));
    tbl.push_back(mk(0, 16'hE6D0, 8'hE4, 0, 1,  1, 1, 0, 0, 8'h1B));
    tbl.push_back(mk(0, 16'hE6D0, 8'h00, 1, 0,  1, 1, 0, 0, 8'h04));
    tbl.push_back(mk(0, 16'h0200, 8'h00, 1, 1,  0, 0, 1, 0, 8'h04));
    tbl.push_back(mk(0, 16'h0200, 8'h00, 1, 0,  1, 1, 0, 0, 8'h04));
    tbl.push_back(mk(0, 16'h0200, 8'h00, 1, 1,  0, 0, 1, 0, 8'h04));
    tbl.push_back(mk(1, 16'h0200, 8'h00, 1, 1,  1, 1, 0, 0, 8'h04));
    tbl.push_back(mk(0, 16'h0200, 8'h00, 1, 1,  0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 16'h0000, 8'h00, 1, 0,  1, 1, 0, 0, 8'h00));

    apply(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);
    advance();

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].ad, tbl[i].di, tbl[i].rw, tbl[i].vma);
      chk($sformatf("vec%0d_ready_w1", i), rd1, tbl[i].r1);
      chk($sformatf("vec%0d_ready_w3", i), rd3, tbl[i].r3);
      chk($sformatf("vec%0d_ready_w0", i), rd0, 1'b1);
      chk($sformatf("vec%0d_sram_cs", i), cs1, tbl[i].cs);
      chk($sformatf("vec%0d_page_sel", i), ps1, tbl[i].ps);
      chk($sformatf("vec%0d_DO", i), do3, tbl[i].dout);
      chk($sformatf("vec%0d_page", i), pg1, tbl[i].dout[4:0]);
      advance();
    end

    // randomized traffic: SRAM, I/O window, page register, held addresses, aborts and resets
    a = 16'h0100;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: a = 16'hE6D0;
        1: a = 16'hE600 + 16'($urandom_range(0, 255));
        2: a = 16'($urandom_range(0, 65535));
        default: ;
      endcase
      apply($urandom_range(0, 49) == 0, a, 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), $urandom_range(0, 6) != 0);
      model_check();
      advance();
    end

    // address sweep of reads; dense around both window edges
    apply(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);
    advance();
    for (int x = 0; x < 65536; x += step) begin
      apply(1'b0, 16'(x), 8'h00, 1'b1, 1'b1);
      model_check();
      advance();
      step = ((x >= 16'hE5F0) && (x < 16'hE710)) ? 1 : 7;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
